// File: rtl/fpu_div_frac_iter_if.sv
// Request/response bundle between the operand queue, the fraction divider
// and the divide exponent/rounding stage.
interface fpu_div_frac_iter_if #(
    parameter int FRAC_W = 53,
    parameter int CNT_W  = 6
);
    logic              in_vld;
    logic              in_rdy;
    logic              in_dbl;
    logic [FRAC_W-1:0] in_a;
    logic [FRAC_W-1:0] in_b;
    logic              out_vld;
    logic              out_rdy;
    logic [FRAC_W+1:0] out_quo;
    logic              out_sticky;
    logic [CNT_W-1:0]  out_shl_a;
    logic [CNT_W-1:0]  out_shl_b;
    logic              out_dbz;

    modport master (
        output in_vld, in_dbl, in_a, in_b, out_rdy,
        input  in_rdy, out_vld, out_quo, out_sticky, out_shl_a, out_shl_b, out_dbz
    );

    modport slave (
        input  in_vld, in_dbl, in_a, in_b, out_rdy,
        output in_rdy, out_vld, out_quo, out_sticky, out_shl_a, out_shl_b, out_dbz
    );
endinterface

// File: rtl/fpu_div_frac_iter.sv
// Self-sequencing radix-2 restoring mantissa divider: normalises both operands,
// then produces one quotient bit per cycle for double or single precision.
module fpu_div_frac_iter #(
    parameter int FRAC_W = 53,
    parameter int SNG_W  = 24,
    parameter int CNT_W  = 6
) (
    input  logic                 rclk,
    input  logic                 rst,
    fpu_div_frac_iter_if.slave   bus,
    input  logic                 abort,
    input  logic                 err_en,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

    localparam logic [CNT_W-1:0] N_DBL = CNT_W'(FRAC_W + 2);
    localparam logic [CNT_W-1:0] N_SNG = CNT_W'(SNG_W + 2);

    state_t            r_state;
    logic              r_in_rdy;
    logic              r_dbl;
    logic [FRAC_W-1:0] r_a;
    logic [FRAC_W-1:0] r_b;
    logic [FRAC_W-1:0] r_bn;
    logic [FRAC_W:0]   r_rem;
    logic [FRAC_W+1:0] r_qacc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_vld;
    logic [FRAC_W+1:0] r_quo;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_shl_a;
    logic [CNT_W-1:0]  r_shl_b;
    logic              r_dbz;

    logic [FRAC_W-1:0] w_sng_mask;
    logic [FRAC_W-1:0] w_in_a;
    logic [FRAC_W-1:0] w_in_b;
    logic [CNT_W-1:0]  w_lzc_a;
    logic [CNT_W-1:0]  w_lzc_b;
    logic [FRAC_W-1:0] w_a_norm;
    logic [FRAC_W-1:0] w_b_norm;
    logic [FRAC_W+1:0] w_d;
    logic              w_q;
    logic [FRAC_W:0]   w_rem_sel;
    logic [FRAC_W+1:0] w_qnext;
    logic [FRAC_W+1:0] w_qfinal;
    logic [FRAC_W+1:0] w_err;

    // Single precision only owns the top SNG_W bits of each mantissa.
    for (genvar gi = 0; gi < FRAC_W; gi++) begin : g_sng_mask
        assign w_sng_mask[gi] = (gi >= FRAC_W - SNG_W);
    end

    function automatic logic [CNT_W-1:0] lzc(input logic [FRAC_W-1:0] v);
        logic [CNT_W-1:0] n;
        logic             found;
        n     = CNT_W'(FRAC_W);
        found = 1'b0;
        for (int i = FRAC_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = CNT_W'(FRAC_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign w_in_a    = bus.in_dbl ? bus.in_a : (bus.in_a & w_sng_mask);
    assign w_in_b    = bus.in_dbl ? bus.in_b : (bus.in_b & w_sng_mask);
    assign w_lzc_a   = lzc(r_a);
    assign w_lzc_b   = lzc(r_b);
    assign w_a_norm  = r_a << w_lzc_a;
    assign w_b_norm  = r_b << w_lzc_b;

    // A negative trial difference shows up as a set top bit.
    assign w_d       = {1'b0, r_rem} - {2'b00, r_bn};
    assign w_q       = ~w_d[FRAC_W+1];
    assign w_rem_sel = w_q ? w_d[FRAC_W:0] : r_rem;
    assign w_qnext   = {r_qacc[FRAC_W:0], w_q};
    assign w_qfinal  = r_dbl ? w_qnext : (w_qnext << (FRAC_W - SNG_W));
    assign w_err     = {{(FRAC_W+1){1'b0}}, err_en};

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_in_rdy  <= 1'b0;
            r_dbl     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_bn      <= '0;
            r_rem     <= '0;
            r_qacc    <= '0;
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
            r_quo     <= '0;
            r_sticky  <= 1'b0;
            r_shl_a   <= '0;
            r_shl_b   <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_rdy <= 1'b1;
                    if (r_in_rdy && bus.in_vld) begin
                        r_a      <= w_in_a;
                        r_b      <= w_in_b;
                        r_dbl    <= bus.in_dbl;
                        r_in_rdy <= 1'b0;
                        r_state  <= NORM;
                    end
                end
                NORM: begin
                    if (abort) begin
                        r_state  <= IDLE;
                        r_in_rdy <= 1'b1;
                    end else begin
                        r_shl_a  <= w_lzc_a;
                        r_shl_b  <= w_lzc_b;
                        r_sticky <= 1'b0;
                        if (r_b == '0) begin
                            r_dbz   <= 1'b1;
                            r_quo   <= ~w_err;
                            r_state <= DONE;
                        end else if (r_a == '0) begin
                            r_dbz   <= 1'b0;
                            r_quo   <= w_err;
                            r_state <= DONE;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_rem   <= {1'b0, w_a_norm};
                            r_bn    <= w_b_norm;
                            r_qacc  <= '0;
                            r_cnt   <= r_dbl ? N_DBL : N_SNG;
                            r_state <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (abort) begin
                        r_state  <= IDLE;
                        r_in_rdy <= 1'b1;
                    end else begin
                        r_rem  <= {w_rem_sel[FRAC_W-1:0], 1'b0};
                        r_qacc <= w_qnext;
                        r_cnt  <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_quo    <= w_qfinal ^ w_err;
                            r_sticky <= (w_rem_sel != '0);
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Result registers settle on entry; out_vld follows one cycle later.
                    if (abort || (r_out_vld && bus.out_rdy)) begin
                        r_state   <= IDLE;
                        r_out_vld <= 1'b0;
                        r_in_rdy  <= 1'b1;
                    end else begin
                        r_out_vld <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_rdy     = r_in_rdy;
    assign bus.out_vld    = r_out_vld;
    assign bus.out_quo    = r_quo;
    assign bus.out_sticky = r_sticky;
    assign bus.out_shl_a  = r_shl_a;
    assign bus.out_shl_b  = r_shl_b;
    assign bus.out_dbz    = r_dbz;
    assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_fpu_div_frac_iter.sv
// Bench for fpu_div_frac_iter: directed vector table, control corner cases and
// random operands checked against an arithmetic divide model.
module tb_fpu_div_frac_iter;
    localparam int FW = 53;
    localparam int SW = 24;
    localparam int CW = 6;

    logic rclk   = 1'b0;
    logic rst    = 1'b1;
    logic abort  = 1'b0;
    logic err_en = 1'b0;
    logic busy;

    fpu_div_frac_iter_if #(.FRAC_W(FW), .CNT_W(CW)) bus ();

    fpu_div_frac_iter #(.FRAC_W(FW), .SNG_W(SW), .CNT_W(CW)) dut (
        .rclk   (rclk),
        .rst    (rst),
        .bus    (bus.slave),
        .abort  (abort),
        .err_en (err_en),
        .busy   (busy)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [54:0] quo;
        logic        sticky;
        logic [5:0]  sa;
        logic [5:0]  sb;
        logic        dbz;
        int          lat;
        logic        a_nz;
        logic        b_nz;
    } res_t;

    typedef struct {
        logic        dbl;
        logic [52:0] a;
        logic [52:0] b;
        res_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int lz(input logic [52:0] v);
        for (int i = 52; i >= 0; i--)
            if (v[i]) return 52 - i;
        return 53;
    endfunction

    // Quotient = floor(a/b * 2^(N-1)) on normalised mantissas, left-justified.
    function automatic res_t model(input logic dbl, input logic [52:0] a_in, input logic [52:0] b_in);
        res_t         r;
        logic [52:0]  m;
        logic [52:0]  a;
        logic [52:0]  b;
        logic [127:0] num;
        logic [127:0] q;
        logic [127:0] rm;
        int           n;
        m = '1;
        m = m << (FW - SW);
        a = dbl ? a_in : (a_in & m);
        b = dbl ? b_in : (b_in & m);
        n = dbl ? FW + 2 : SW + 2;
        r.sa = 6'(lz(a));
        r.sb = 6'(lz(b));
        r.a_nz = (a != 0);
        r.b_nz = (b != 0);
        r.sticky = 1'b0;
        r.dbz = 1'b0;
        if (b == 0) begin
            r.dbz = 1'b1;
            r.quo = '1;
            r.lat = 2;
        end else if (a == 0) begin
            r.quo = '0;
            r.lat = 2;
        end else begin
            num = 128'(a << r.sa) << (n - 1);
            q   = num / 128'(b << r.sb);
            rm  = num % 128'(b << r.sb);
            r.quo = 55'(q) << (FW + 2 - n);
            r.sticky = (rm != 0);
            r.lat = n + 2;
        end
        return r;
    endfunction

    task automatic start_op(input logic dbl, input logic [52:0] a, input logic [52:0] b);
        int w = 0;
        while (!bus.in_rdy && w < 20) begin
            @(negedge rclk);
            w++;
        end
        chk("in_rdy_before_req", 64'(bus.in_rdy), 64'd1);
        bus.in_dbl = dbl;
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_vld = 1'b1;
        @(negedge rclk);
        bus.in_vld = 1'b0;
    endtask

    task automatic do_op(input logic dbl, input logic [52:0] a, input logic [52:0] b,
                         input int hold, output res_t r);
        start_op(dbl, a, b);
        r.lat = 0;
        while (!bus.out_vld && r.lat < 200) begin
            @(negedge rclk);
            r.lat++;
        end
        r.quo    = bus.out_quo;
        r.sticky = bus.out_sticky;
        r.sa     = bus.out_shl_a;
        r.sb     = bus.out_shl_b;
        r.dbz    = bus.out_dbz;
        r.a_nz   = 1'b0;
        r.b_nz   = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge rclk);
            chk("hold_vld", 64'(bus.out_vld), 64'd1);
            chk("hold_quo", 64'(bus.out_quo), 64'(r.quo));
            chk("hold_flags", 64'({bus.out_sticky, bus.out_dbz, bus.out_shl_a, bus.out_shl_b}),
                64'({r.sticky, r.dbz, r.sa, r.sb}));
        end
        bus.out_rdy = 1'b1;
        @(negedge rclk);
        bus.out_rdy = 1'b0;
        chk("vld_drop_after_accept", 64'(bus.out_vld), 64'd0);
        $display("op dbl=%0d a=%h b=%h -> quo=%h sticky=%0d dbz=%0d shl=%0d/%0d lat=%0d",
                 dbl, a, b, r.quo, r.sticky, r.dbz, r.sa, r.sb, r.lat);
    endtask

    task automatic cmp(input string tag, input res_t g, input res_t e);
        chk({tag, "_quo"}, 64'(g.quo), 64'(e.quo));
        chk({tag, "_sticky"}, 64'(g.sticky), 64'(e.sticky));
        chk({tag, "_dbz"}, 64'(g.dbz), 64'(e.dbz));
        chk({tag, "_lat"}, 64'(g.lat), 64'(e.lat));
        if (e.a_nz) chk({tag, "_shl_a"}, 64'(g.sa), 64'(e.sa));
        if (e.b_nz) chk({tag, "_shl_b"}, 64'(g.sb), 64'(e.sb));
    endtask

    vec_t vecs[9];

    initial begin
        res_t got;
        res_t exp;
        logic seen;
        logic [52:0] ra;
        logic [52:0] rb;
        logic rd;

        // {quo, sticky, shl_a, shl_b, dbz, latency, check shl_a, check shl_b}
        vecs[0] = '{1'b1, 53'h10000000000000, 53'h10000000000000, '{55'h40000000000000, 1'b0, 6'd0,  6'd0, 1'b0, 57, 1'b1, 1'b1}};
        vecs[1] = '{1'b1, 53'h10000000000000, 53'h18000000000000, '{55'h2AAAAAAAAAAAAA, 1'b1, 6'd0,  6'd0, 1'b0, 57, 1'b1, 1'b1}};
        vecs[2] = '{1'b1, 53'h00000000000001, 53'h10000000000000, '{55'h40000000000000, 1'b0, 6'd52, 6'd0, 1'b0, 57, 1'b1, 1'b1}};
        vecs[3] = '{1'b0, 53'h10000000000000, 53'h10000000000000, '{55'h40000000000000, 1'b0, 6'd0,  6'd0, 1'b0, 28, 1'b1, 1'b1}};
        vecs[4] = '{1'b1, 53'h10000000000000, 53'h00000000000000, '{55'h7FFFFFFFFFFFFF, 1'b0, 6'd0,  6'd0, 1'b1, 2,  1'b0, 1'b0}};
        vecs[5] = '{1'b1, 53'h00000000000000, 53'h10000000000000, '{55'h00000000000000, 1'b0, 6'd0,  6'd0, 1'b0, 2,  1'b0, 1'b0}};
        vecs[6] = '{1'b0, 53'h10000000000000, 53'h18000000000000, '{55'h2AAAAAA0000000, 1'b1, 6'd0,  6'd0, 1'b0, 28, 1'b1, 1'b1}};
        vecs[7] = '{1'b1, 53'h1FFFFFFFFFFFFF, 53'h10000000000000, '{55'h7FFFFFFFFFFFFC, 1'b0, 6'd0,  6'd0, 1'b0, 57, 1'b1, 1'b1}};
        vecs[8] = '{1'b0, 53'h10000000000001, 53'h10000000000000, '{55'h40000000000000, 1'b0, 6'd0,  6'd0, 1'b0, 28, 1'b1, 1'b1}};

        bus.in_vld = 1'b0;
        bus.in_dbl = 1'b0;
        bus.in_a   = '0;
        bus.in_b   = '0;
        bus.out_rdy = 1'b0;

        repeat (2) @(negedge rclk);
        chk("reset_in_rdy", 64'(bus.in_rdy), 64'd0);
        chk("reset_out_vld", 64'(bus.out_vld), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_quo", 64'(bus.out_quo), 64'd0);
        rst = 1'b0;
        @(negedge rclk);
        chk("in_rdy_after_reset", 64'(bus.in_rdy), 64'd1);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].dbl, vecs[i].a, vecs[i].b, 0, got);
            cmp($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Fault hook flips the quotient LSB at DONE entry.
        err_en = 1'b1;
        do_op(1'b1, 53'h10000000000000, 53'h10000000000000, 0, got);
        err_en = 1'b0;
        chk("err_en_quo", 64'(got.quo), 64'h40000000000001);

        // Consumer stalls for 5 cycles.
        do_op(1'b1, 53'h10000000000000, 53'h18000000000000, 5, got);
        cmp("hold", got, vecs[1].exp);

        // Abort during the 10th ITER cycle.
        start_op(1'b1, 53'h10000000000000, 53'h18000000000000);
        repeat (10) @(negedge rclk);
        chk("abort_pre_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge rclk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_rdy", 64'(bus.in_rdy), 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(negedge rclk);
            if (bus.out_vld) seen = 1'b1;
        end
        chk("abort_no_out_vld", 64'(seen), 64'd0);
        do_op(1'b1, 53'h10000000000000, 53'h18000000000000, 0, got);
        cmp("post_abort", got, vecs[1].exp);

        // abort together with out_rdy in DONE.
        start_op(1'b1, 53'h10000000000000, 53'h0);
        for (int w = 0; w < 10 && !bus.out_vld; w++) @(negedge rclk);
        chk("done_abort_pre_vld", 64'(bus.out_vld), 64'd1);
        abort = 1'b1;
        bus.out_rdy = 1'b1;
        @(negedge rclk);
        abort = 1'b0;
        bus.out_rdy = 1'b0;
        chk("done_abort_vld", 64'(bus.out_vld), 64'd0);
        chk("done_abort_in_rdy", 64'(bus.in_rdy), 64'd1);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = 53'({$urandom, $urandom});
            rb = 53'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 52);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 52);
            if ($urandom_range(0, 9) == 0) ra = '0;
            if ($urandom_range(0, 9) == 0) rb = '0;
            rd = 1'($urandom_range(0, 1));
            exp = model(rd, ra, rb);
            do_op(rd, ra, rb, 0, got);
            cmp($sformatf("rand%0d", i), got, exp);
        end

        // Reset pulse mid-ITER clears every output at once.
        start_op(1'b1, 53'h1, 53'h10000000000000);
        repeat (12) @(negedge rclk);
        chk("rst_pre_shl_a", 64'(bus.out_shl_a), 64'd52);
        rst = 1'b1;
        #1;
        chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
        chk("rst_in_rdy", 64'(bus.in_rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_quo", 64'(bus.out_quo), 64'd0);
        chk("rst_flags", 64'({bus.out_sticky, bus.out_dbz, bus.out_shl_a, bus.out_shl_b}), 64'd0);
        @(negedge rclk);
        rst = 1'b0;
        @(negedge rclk);
        chk("rst_release_in_rdy", 64'(bus.in_rdy), 64'd1);
        do_op(1'b1, 53'h00000000000001, 53'h10000000000000, 0, got);
        cmp("post_rst", got, vecs[2].exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
